// File: rtl/vga_pkg.sv
// Shared VGA geometry, colour constants and fill-engine state encoding.
// Used by the rectangle filler and the game logic above it.
package vga_pkg;

  localparam int XW   = 8;
  localparam int YW   = 7;
  localparam int CW   = 3;
  localparam int XMAX = 160;
  localparam int YMAX = 120;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } state_t;

  localparam logic [CW-1:0] BLACK = 3'b000;
  localparam logic [CW-1:0] RED   = 3'b100;
  localparam logic [CW-1:0] GREEN = 3'b010;
  localparam logic [CW-1:0] WHITE = 3'b111;

endpackage

// File: rtl/raster_counter.sv
// Row-major 2-D pixel counter for the rectangle filler.
// Flags the last column of a row and the last pixel of the rectangle.
module raster_counter #(
  parameter int XW = 8,
  parameter int YW = 7
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          load,
  input  logic          en,
  input  logic [XW-1:0] w,
  input  logic [YW-1:0] h,
  output logic [XW-1:0] cx,
  output logic [YW-1:0] cy,
  output logic          eol,
  output logic          last
);

  assign eol  = (cx == w - 1'b1);
  assign last = eol && (cy == h - 1'b1);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cx <= '0;
      cy <= '0;
    end else if (load) begin
      cx <= '0;
      cy <= '0;
    end else if (en) begin
      if (eol) begin
        cx <= '0;
        cy <= cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rect_fill_engine.sv
// Filled-rectangle pixel generator feeding vga_adapter, one pixel per clock.
// Define RECT_FILL_CLIP_EN to suppress plot for pixels off the 160x120 screen.
module rect_fill_engine #(
  parameter int XW = vga_pkg::XW,
  parameter int YW = vga_pkg::YW,
  parameter int CW = vga_pkg::CW
`ifdef RECT_FILL_CLIP_EN
  ,
  parameter int XMAX = vga_pkg::XMAX,
  parameter int YMAX = vga_pkg::YMAX
`endif
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] w,
  input  logic [YW-1:0] h,
  input  logic [CW-1:0] colour_in,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] colour,
  output logic          plot
);

  import vga_pkg::*;

  state_t state;

  logic [XW-1:0] x0_r;
  logic [XW-1:0] w_r;
  logic [YW-1:0] y0_r;
  logic [YW-1:0] h_r;
  logic [CW-1:0] col_r;

  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic          eol;
  logic          last;
  logic          load;
  logic          en;
  logic          empty;

  logic [XW-1:0] ax;
  logic [XW-1:0] bx;
  logic [YW-1:0] ay;
  logic [YW-1:0] by;
  logic [XW-1:0] xo;
  logic [YW-1:0] yo;
  logic          vis;

  assign load  = (state == IDLE) && start;
  assign en    = (state == DRAW);
  assign empty = (w == '0) || (h == '0);

  raster_counter #(
    .XW(XW),
    .YW(YW)
  ) u_cnt (
    .clock (clock),
    .resetn(resetn),
    .load  (load),
    .en    (en),
    .w     (w_r),
    .h     (h_r),
    .cx    (cx),
    .cy    (cy),
    .eol   (eol),
    .last  (last)
  );

  // Operands of the pixel that will be presented after the coming edge.
  always_comb begin
    ax = x0_r;
    ay = y0_r;
    bx = '0;
    by = cy;
    if (state == IDLE) begin
      ax = x0;
      ay = y0;
      by = '0;
    end else if (eol) begin
      by = cy + 1'b1;
    end else begin
      bx = cx + 1'b1;
    end
  end

`ifdef RECT_FILL_CLIP_EN
  localparam logic [XW:0] XLIM = (XW+1)'(XMAX);
  localparam logic [YW:0] YLIM = (YW+1)'(YMAX);

  logic [XW:0] xs;
  logic [YW:0] ys;

  assign xs  = {1'b0, ax} + {1'b0, bx};
  assign ys  = {1'b0, ay} + {1'b0, by};
  assign xo  = xs[XW-1:0];
  assign yo  = ys[YW-1:0];
  assign vis = (xs < XLIM) && (ys < YLIM);
`else
  assign xo  = ax + bx;
  assign yo  = ay + by;
  assign vis = 1'b1;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      x0_r   <= '0;
      y0_r   <= '0;
      w_r    <= '0;
      h_r    <= '0;
      col_r  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          plot <= 1'b0;
          if (start) begin
            x0_r  <= x0;
            y0_r  <= y0;
            w_r   <= w;
            h_r   <= h;
            col_r <= colour_in;
            busy  <= 1'b1;
            if (empty) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state  <= DRAW;
              plot   <= vis;
              x      <= xo;
              y      <= yo;
              colour <= colour_in;
            end
          end
        end
        DRAW: begin
          if (last) begin
            state <= DONE;
            plot  <= 1'b0;
            done  <= 1'b1;
          end else begin
            plot   <= vis;
            x      <= xo;
            y      <= yo;
            colour <= col_r;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          plot  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Randomised self-checking bench for rect_fill_engine against a
// cycle-stream reference model built from the rectangle geometry.
module tb_rect_fill_engine;

  import vga_pkg::*;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x0 = '0;
  logic [6:0] y0 = '0;
  logic [7:0] w = '0;
  logic [6:0] h = '0;
  logic [2:0] colour_in = '0;
  logic       busy;
  logic       done;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  rect_fill_engine dut (
    .clock    (clock),
    .resetn   (resetn),
    .start    (start),
    .x0       (x0),
    .y0       (y0),
    .w        (w),
    .h        (h),
    .colour_in(colour_in),
    .busy     (busy),
    .done     (done),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit busy;
    bit done;
    bit draw;
    bit plot;
    int x;
    int y;
    int col;
  } exp_t;

  typedef struct {
    int x;
    int y;
    int col;
    int cyc;
  } px_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_on = 0;
  exp_t q[$];
  exp_t cur = '{default: 0};
  px_t  plog[$];
  int   cyc = 0;
  int   nbusy = 0;
  int   ndone = 0;
  int   done_cyc = 0;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t idle_e();
    exp_t e = '{default: 0};
    return e;
  endfunction

  // Expected output stream: w*h pixels row-major, then one done cycle.
  function automatic void build(int ax, int ay, int aw, int ah, int ac);
    exp_t e;
    for (int r = 0; r < ah; r++) begin
      for (int c = 0; c < aw; c++) begin
        e = '{default: 0};
        e.busy = 1;
        e.draw = 1;
        e.x    = (ax + c) % 256;
        e.y    = (ay + r) % 128;
        e.col  = ac;
`ifdef RECT_FILL_CLIP_EN
        e.plot = (ax + c < 160) && (ay + r < 120);
`else
        e.plot = 1;
`endif
        q.push_back(e);
      end
    end
    e = '{default: 0};
    e.busy = 1;
    e.done = 1;
    q.push_back(e);
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      q.delete();
      cur <= idle_e();
    end else begin
      if (!cur.busy && start)
        build(int'(x0), int'(y0), int'(w), int'(h), int'(colour_in));
      cur <= (q.size() > 0) ? q.pop_front() : idle_e();
    end
  end

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (chk_on && resetn) begin
      chk("busy", int'(busy), int'(cur.busy));
      chk("done", int'(done), int'(cur.done));
      chk("plot", int'(plot), int'(cur.plot));
      if (cur.draw) begin
        chk("x", int'(x), cur.x);
        chk("y", int'(y), cur.y);
        chk("colour", int'(colour), cur.col);
      end
    end
  end

  always @(negedge clock) begin
    if (plot) plog.push_back('{int'(x), int'(y), int'(colour), cyc});
    if (busy) nbusy <= nbusy + 1;
    if (done) begin
      ndone    <= ndone + 1;
      done_cyc <= cyc;
    end
  end

  task automatic go(int ax, int ay, int aw, int ah, int ac);
    @(negedge clock);
    x0 = 8'(ax);
    y0 = 7'(ay);
    w = 8'(aw);
    h = 7'(ah);
    colour_in = 3'(ac);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle(int lim);
    bit ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clock);
      #1;
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    chk("idle_reached", int'(ok), 1);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0, b0, d0, n, k;
    int ex_x[6] = '{10, 11, 12, 10, 11, 12};
    int ex_y[6] = '{20, 20, 20, 21, 21, 21};

    repeat (3) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_plot", int'(plot), 0);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_colour", int'(colour), 0);
    chk_on = 1;

    // Basic 3x2 fill
    p0 = plog.size(); b0 = nbusy; d0 = ndone;
    go(10, 20, 3, 2, int'(GREEN));
    wait_idle(100);
    n = plog.size() - p0;
    chk("t1_nplot", n, 6);
    for (int i = 0; i < 6 && i < n; i++) begin
      chk("t1_px", plog[p0+i].x, ex_x[i]);
      chk("t1_py", plog[p0+i].y, ex_y[i]);
      chk("t1_pcol", plog[p0+i].col, 2);
    end
    chk("t1_busy_cycles", nbusy - b0, 7);
    chk("t1_ndone", ndone - d0, 1);
    if (n > 0) chk("t1_done_after_last", done_cyc, plog[plog.size()-1].cyc + 1);

    // Empty rectangle
    p0 = plog.size(); b0 = nbusy; d0 = ndone;
    go(5, 5, 0, 5, int'(RED));
    #1;
    chk("t2_done_now", int'(done), 1);
    wait_idle(20);
    chk("t2_nplot", plog.size() - p0, 0);
    chk("t2_busy_cycles", nbusy - b0, 1);
    chk("t2_ndone", ndone - d0, 1);

    // Start and input changes during a fill are ignored
    p0 = plog.size(); d0 = ndone;
    go(30, 40, 4, 4, int'(RED));
    repeat (3) @(negedge clock);
    x0 = 8'd1; y0 = 7'd1; w = 8'd9; h = 7'd9; colour_in = WHITE;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_idle(100);
    n = plog.size() - p0;
    chk("t3_nplot", n, 16);
    for (int i = 0; i < 16 && i < n; i++) begin
      chk("t3_px", plog[p0+i].x, 30 + i % 4);
      chk("t3_py", plog[p0+i].y, 40 + i / 4);
      chk("t3_pcol", plog[p0+i].col, 4);
    end
    chk("t3_ndone", ndone - d0, 1);

    // Reset after the 5th plot of an 8x8 fill
    p0 = plog.size(); d0 = ndone;
    go(0, 0, 8, 8, int'(WHITE));
    k = 0;
    for (int i = 0; i < 100; i++) begin
      if (plog.size() - p0 >= 5) begin
        k = 1;
        break;
      end
      @(negedge clock);
      #1;
    end
    chk("t4_reached_5", k, 1);
    #1;
    resetn = 1'b0;
    #1;
    chk("t4_plot_low", int'(plot), 0);
    chk("t4_busy_low", int'(busy), 0);
    chk("t4_done_low", int'(done), 0);
    @(posedge clock);
    @(negedge clock);
    #2;
    resetn = 1'b1;
    @(negedge clock);
    chk("t4_no_done", ndone - d0, 0);
    p0 = plog.size();
    go(2, 3, 2, 2, int'(GREEN));
    wait_idle(50);
    n = plog.size() - p0;
    chk("t4_nplot_after", n, 4);
    if (n > 0) begin
      chk("t4_first_x", plog[p0].x, 2);
      chk("t4_first_y", plog[p0].y, 3);
    end

    // Screen edge
    p0 = plog.size(); b0 = nbusy; d0 = ndone;
    go(158, 118, 4, 4, int'(WHITE));
    wait_idle(50);
    n = plog.size() - p0;
`ifdef RECT_FILL_CLIP_EN
    chk("t5_nplot", n, 4);
    if (n == 4) begin
      chk("t5_last_x", plog[p0+3].x, 159);
      chk("t5_last_y", plog[p0+3].y, 119);
    end
`else
    chk("t5_nplot", n, 16);
    if (n == 16) begin
      chk("t5_last_x", plog[p0+15].x, 161);
      chk("t5_last_y", plog[p0+15].y, 121);
    end
`endif
    chk("t5_busy_cycles", nbusy - b0, 17);
    chk("t5_ndone", ndone - d0, 1);

    // Start held high with 1x1 rectangles
    p0 = plog.size(); d0 = ndone;
    @(negedge clock);
    x0 = 8'd50; y0 = 7'd60; w = 8'd1; h = 7'd1; colour_in = RED;
    start = 1'b1;
    repeat (12) @(negedge clock);
    start = 1'b0;
    wait_idle(20);
    n = plog.size() - p0;
    chk("t6_nplot", n, 4);
    for (int i = 1; i < n; i++)
      chk("t6_period", plog[p0+i].cyc - plog[p0+i-1].cyc, 3);
    chk("t6_ndone", ndone - d0, 4);

    // Randomised rectangles, some near the wrap/clip edges
    for (int it = 0; it < 60; it++) begin
      int ax, ay, aw, ah, ac;
      ax = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 255) : $urandom_range(0, 255);
      ay = ($urandom_range(0, 3) == 0) ? $urandom_range(110, 127) : $urandom_range(0, 127);
      aw = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
      ah = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 10);
      ac = $urandom_range(0, 7);
      go(ax, ay, aw, ah, ac);
      if ($urandom_range(0, 2) == 0) begin
        x0 = 8'($urandom_range(0, 255));
        w = 8'($urandom_range(0, 255));
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
      end
      wait_idle(300);
    end

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
